// File: rtl/rd_port_arbiter.sv
// Round-robin arbiter sharing one memory read port among NUM_REQ requesters.
// An in-order tag FIFO remembers each in-flight read's owner so returned data can be routed back.
module rd_port_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int SIZE_ADDR = 8,
  parameter int SIZE_DATA = 8,
  parameter int MAX_OUT   = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_REQ-1:0]           i_req,
  input  logic [NUM_REQ*SIZE_ADDR-1:0] i_addr,
  output logic [NUM_REQ-1:0]           o_gnt,
  output logic                         o_mem_rd_en,
  output logic [SIZE_ADDR-1:0]         o_mem_addr,
  input  logic                         i_mem_valid,
  input  logic [SIZE_DATA-1:0]         i_mem_data,
  output logic [NUM_REQ-1:0]           o_resp_valid,
  output logic [SIZE_DATA-1:0]         o_resp_data,
  output logic                         o_busy,
  output logic                         o_err
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int FP_W  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     gnt_idx, cand;
  logic                 gnt_any, full, push, pop;
  logic [PTR_W-1:0]     tag_mem_q [MAX_OUT];
  logic [FP_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
  logic [SIZE_DATA-1:0] resp_data_q, resp_data_d;
  logic                 err_q, err_d;

  assign full = (count_q == CNT_W'(MAX_OUT));

  // A full FIFO blocks grants even if a slot frees this cycle; reset also forces no grant.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!gnt_any && i_req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (full || !i_rst_n) gnt_any = 1'b0;
  end

  assign push        = gnt_any;
  assign pop         = i_mem_valid && (count_q != '0);
  assign o_gnt       = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign o_mem_rd_en = gnt_any;
  assign o_mem_addr  = gnt_any ? i_addr[gnt_idx*SIZE_ADDR +: SIZE_ADDR] : '0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
      wr_ptr_d = (wr_ptr_q == FP_W'(MAX_OUT - 1)) ? '0 : wr_ptr_q + FP_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == FP_W'(MAX_OUT - 1)) ? '0 : rd_ptr_q + FP_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    resp_valid_d = pop ? (NUM_REQ'(1) << tag_mem_q[rd_ptr_q]) : '0;
    resp_data_d  = pop ? i_mem_data : resp_data_q;
    err_d        = err_q | (i_mem_valid && (count_q == '0));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      err_q        <= 1'b0;
      for (int j = 0; j < MAX_OUT; j++) tag_mem_q[j] <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      err_q        <= err_d;
      if (push) tag_mem_q[wr_ptr_q] <= gnt_idx;
    end
  end

  assign o_resp_valid = resp_valid_q;
  assign o_resp_data  = resp_data_q;
  assign o_busy       = (count_q != '0);
  assign o_err        = err_q;

endmodule

// File: tb/tb_rd_port_arbiter.sv
// Bench for rd_port_arbiter: queue-based reference model drives expectations, a negedge monitor
// pops the response scoreboard and checks every returned word and idle cycle.
module tb_rd_port_arbiter;
  localparam int NR = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int MO = 4;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic [NR-1:0]    i_req = '0;
  logic [NR*AW-1:0] i_addr = '0;
  logic             i_mem_valid = 1'b0;
  logic [DW-1:0]    i_mem_data = '0;
  logic [NR-1:0]    o_gnt;
  logic             o_mem_rd_en;
  logic [AW-1:0]    o_mem_addr;
  logic [NR-1:0]    o_resp_valid;
  logic [DW-1:0]    o_resp_data;
  logic             o_busy;
  logic             o_err;

  rd_port_arbiter #(.NUM_REQ(NR), .SIZE_ADDR(AW), .SIZE_DATA(DW), .MAX_OUT(MO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_addr(i_addr),
    .o_gnt(o_gnt), .o_mem_rd_en(o_mem_rd_en), .o_mem_addr(o_mem_addr),
    .i_mem_valid(i_mem_valid), .i_mem_data(i_mem_data),
    .o_resp_valid(o_resp_valid), .o_resp_data(o_resp_data),
    .o_busy(o_busy), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: list of outstanding owners, round-robin start, sticky error, last response word.
  int            mq[$];
  int            rr = 0;
  bit            m_err = 1'b0;
  logic [DW-1:0] last_data = '0;

  typedef struct {
    int            due;
    int            tag;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NR*AW-1:0] rnd_addr();
    return (NR*AW)'($urandom);
  endfunction

  always @(negedge i_clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("resp_valid", 32'(o_resp_valid), 1 << e.tag);
      chk("resp_data", 32'(o_resp_data), 32'(e.data));
      last_data = e.data;
    end else begin
      chk("resp_idle", 32'(o_resp_valid), 0);
      chk("resp_hold", 32'(o_resp_data), 32'(last_data));
    end
  end

  task automatic step(input logic [NR-1:0] req, input logic [NR*AW-1:0] addr,
                      input logic mv, input logic [DW-1:0] md, output int k);
    int               ek;
    int               h;
    int               rq;
    logic [NR*AW-1:0] sh;
    @(posedge i_clk);
    #1;
    i_req = req; i_addr = addr; i_mem_valid = mv; i_mem_data = md;
    #1;
    ek = -1;
    rq = int'(req);
    if (mq.size() < MO) begin
      for (int i = 0; i < NR; i++) begin
        int c;
        c = (rr + i) % NR;
        if (ek < 0 && ((rq >> c) & 1) == 1) ek = c;
      end
    end
    sh = '0;
    if (ek >= 0) sh = addr >> (ek * AW);
    chk("gnt", 32'(o_gnt), (ek >= 0) ? (1 << ek) : 0);
    chk("rd_en", 32'(o_mem_rd_en), (ek >= 0) ? 1 : 0);
    chk("mem_addr", 32'(o_mem_addr), 32'(sh[AW-1:0]));
    chk("busy", 32'(o_busy), (mq.size() != 0) ? 1 : 0);
    chk("err", 32'(o_err), int'(m_err));
    if (mv) begin
      if (mq.size() > 0) begin
        h = mq.pop_front();
        sb.push_back('{cyc + 1, h, md});
      end else begin
        m_err = 1'b1;
      end
    end
    if (ek >= 0) begin
      mq.push_back(ek);
      rr = (ek + 1) % NR;
    end
    k = ek;
  endtask

  task automatic do_reset(input logic [NR-1:0] hold_req);
    #1;
    i_req = hold_req;
    mq.delete(); sb.delete(); rr = 0; m_err = 1'b0; last_data = '0;
    i_rst_n = 1'b0;
    #1;
    chk("rst_gnt", 32'(o_gnt), 0);
    chk("rst_rd_en", 32'(o_mem_rd_en), 0);
    chk("rst_addr", 32'(o_mem_addr), 0);
    chk("rst_resp_valid", 32'(o_resp_valid), 0);
    chk("rst_resp_data", 32'(o_resp_data), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_err", 32'(o_err), 0);
    i_req = '0; i_mem_valid = 1'b0;
    @(posedge i_clk);
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
  endtask

  initial begin
    int               k;
    logic [NR*AW-1:0] a;
    logic [NR-1:0]    hold;
    logic             mv;

    do_reset('0);

    // Return with nothing in flight
    step('0, rnd_addr(), 1'b1, 8'h77, k);
    step('0, rnd_addr(), 1'b0, '0, k);
    chk("err_set", 32'(o_err), 1);
    chk("err_no_resp", 32'(o_resp_valid), 0);
    step('0, rnd_addr(), 1'b0, '0, k);
    step('0, rnd_addr(), 1'b0, '0, k);
    chk("err_sticky", 32'(o_err), 1);

    // Single request
    do_reset('0);
    a = rnd_addr();
    a[2*AW +: AW] = 8'h3C;
    step(4'b0100, a, 1'b0, '0, k);
    chk("single_gnt", 32'(o_gnt), 4);
    chk("single_rd_en", 32'(o_mem_rd_en), 1);
    chk("single_addr", 32'(o_mem_addr), 'h3C);
    step('0, rnd_addr(), 1'b1, 8'hA5, k);
    step('0, rnd_addr(), 1'b0, '0, k);
    chk("single_resp_valid", 32'(o_resp_valid), 4);
    chk("single_resp_data", 32'(o_resp_data), 'hA5);

    // Round-robin order, then full stall and resume
    do_reset('0);
    for (int i = 0; i < MO; i++) begin
      step(4'hF, rnd_addr(), 1'b0, '0, k);
      chk("rr_order", 32'(o_gnt), 1 << i);
    end
    step(4'hF, rnd_addr(), 1'b0, '0, k);
    chk("full_gnt", 32'(o_gnt), 0);
    chk("full_busy", 32'(o_busy), 1);
    step(4'hF, rnd_addr(), 1'b1, DW'($urandom), k);
    chk("full_ret_gnt", 32'(o_gnt), 0);
    step(4'hF, rnd_addr(), 1'b0, '0, k);
    chk("resume_gnt", 32'(o_gnt), 1);
    for (int i = 0; i < MO; i++) step('0, rnd_addr(), 1'b1, DW'($urandom), k);
    step('0, rnd_addr(), 1'b0, '0, k);

    // Push and pop in the same cycle with two in flight
    step(4'b0001, rnd_addr(), 1'b0, '0, k);
    step(4'b0100, rnd_addr(), 1'b0, '0, k);
    step(4'b0010, rnd_addr(), 1'b1, DW'($urandom), k);
    chk("pp_gnt", 32'(o_gnt), 2);
    step('0, rnd_addr(), 1'b0, '0, k);
    chk("pp_oldest", 32'(o_resp_valid), 1);
    chk("pp_busy", 32'(o_busy), 1);
    step('0, rnd_addr(), 1'b1, DW'($urandom), k);
    step('0, rnd_addr(), 1'b1, DW'($urandom), k);
    chk("pp_second", 32'(o_resp_valid), 4);
    step('0, rnd_addr(), 1'b0, '0, k);
    chk("pp_tag1", 32'(o_resp_valid), 2);

    // Reset with three reads outstanding
    for (int i = 0; i < 3; i++) step(4'b0111, rnd_addr(), 1'b0, '0, k);
    chk("mid_busy", 32'(o_busy), 1);
    do_reset(4'b0111);
    step(4'hF, rnd_addr(), 1'b0, '0, k);
    chk("post_rst_gnt", 32'(o_gnt), 1);

    // Random traffic: requests held until granted, in-order returns
    hold = '0;
    repeat (400) begin
      hold |= NR'($urandom & $urandom);
      mv = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
      step(hold, rnd_addr(), mv, DW'($urandom), k);
      if (k >= 0) hold &= ~(NR'(1) << k);
    end
    for (int i = 0; i < MO + 1; i++) begin
      if (mq.size() > 0) step('0, rnd_addr(), 1'b1, DW'($urandom), k);
    end
    step('0, rnd_addr(), 1'b0, '0, k);
    step('0, rnd_addr(), 1'b0, '0, k);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rd_port_arbiter.md
# rd_port_arbiter

Round-robin arbiter that shares one memory read port among NUM_REQ requesters. It sits upstream of the read-data pipeline stage. Each cycle it grants at most one requester and drives the read enable and address into the stage. It records the owner of every in-flight read in an in-order tag FIFO, then routes each returned data word, with a per-requester valid, back to its owner.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- SIZE_ADDR, 8, read address width
- SIZE_DATA, 8, read data width
- MAX_OUT, 4, maximum reads in flight (tag FIFO depth, 1..8)
- i_clk  in  1  clock; all state updates on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_req  in  NUM_REQ  per-requester read request, held until granted
- i_addr  in  NUM_REQ*SIZE_ADDR  packed addresses; requester k uses bits [k*SIZE_ADDR +: SIZE_ADDR]
- o_gnt  out  NUM_REQ  one-hot grant, combinational; transfer when i_req[k] & o_gnt[k]
- o_mem_rd_en  out  1  read issue to read stage, equals |o_gnt
- o_mem_addr  out  SIZE_ADDR  address of granted requester, 0 when no grant
- i_mem_valid  in  1  one pulse per issued read, returned in issue order
- i_mem_data  in  SIZE_DATA  read data, qualified by i_mem_valid
- o_resp_valid  out  NUM_REQ  one-hot response strobe, registered
- o_resp_data  out  SIZE_DATA  response data, registered, shared by all requesters
- o_busy  out  1  at least one read in flight (count != 0)
- o_err  out  1  sticky: i_mem_valid received with the tag FIFO empty

## Operation
- State: round-robin pointer rr_ptr (clog2(NUM_REQ) bits, reset 0), tag FIFO of MAX_OUT entries × clog2(NUM_REQ) bits with wr/rd pointers, and count (clog2(MAX_OUT+1) bits, reset 0).
- Arbitration: when count < MAX_OUT, grant the first requester with i_req set, searching from rr_ptr upward modulo NUM_REQ. When count == MAX_OUT, no grant.
- Full with a simultaneous return: no grant in that cycle. The freed slot is usable from the next cycle.
- On grant to k:
  - push k into the tag FIFO;
  - rr_ptr <= (k+1) mod NUM_REQ.
- With no grant, rr_ptr holds.
- On i_mem_valid with count > 0:
  - pop the head tag h;
  - next cycle, o_resp_valid <= one-hot(h) and o_resp_data <= i_mem_data.
- On i_mem_valid with count == 0:
  - no pop and no response;
  - o_err <= 1. o_err clears only on reset.
- Push and pop in the same cycle: count is unchanged, and both FIFO pointers advance. FIFO pointers wrap modulo MAX_OUT.
- o_resp_data holds its last value when o_resp_valid is 0.
- Reset mid-operation: the FIFO is flushed, count = 0 and rr_ptr = 0. The requester side must discard outstanding reads. Returns that arrive after reset count as unexpected and set o_err.

## Timing
- Reset values:
  - o_gnt = 0 and o_mem_rd_en = 0 (forced while i_rst_n is low);
  - o_mem_addr = 0;
  - o_resp_valid = 0 and o_resp_data = 0;
  - o_busy = 0 and o_err = 0.
- Grant latency: o_gnt is combinational from i_req, rr_ptr and count, so it is asserted in the same cycle as the request.
- Issue: o_mem_rd_en and o_mem_addr are valid in the grant cycle, and the read stage samples them on the next edge.
- Response latency: o_resp_valid rises exactly 1 cycle after the i_mem_valid cycle and stays high for 1 cycle per return.
- Throughput: 1 grant per cycle sustained while count < MAX_OUT and 1 response per cycle. Issue-to-return latency is set by the memory side. Correctness relies only on in-order returns.
- o_busy reflects registered count and updates on the edge after a push or pop.

## Test plan
- Single request: i_req=4'b0100, i_addr[2]=8'h3C. Required:
  - o_gnt=4'b0100, o_mem_rd_en=1 and o_mem_addr=8'h3C in the same cycle;
  - i_mem_valid with data 8'hA5 → next cycle o_resp_valid=4'b0100 and o_resp_data=8'hA5.
- Round-robin fairness: i_req=4'b1111 held for 8 cycles with no returns and MAX_OUT=8. Required grants in order 0,1,2,3,0,1,2,3. Then the FIFO is full: o_gnt=0 and o_busy=1.
- Full stall: MAX_OUT=4, 4 grants issued and no return. Required:
  - o_gnt=0 while i_req != 0;
  - return in the next cycle → o_gnt=0 in that cycle, grant resumes the cycle after.
- Simultaneous push/pop: count=2, grant to requester 1 in the same cycle as a return. Required:
  - count stays 2;
  - the response goes to the oldest tag, and tag 1 is returned two returns later.
- Unexpected return: after reset, i_mem_valid=1 with data 8'h77. Required: o_resp_valid stays 0, o_err=1 from the next cycle, and o_err stays 1 until reset.
- Reset mid-flight: 3 reads outstanding, pulse i_rst_n low asynchronously. Required:
  - all outputs go to 0 immediately;
  - after release, first grant search starts from requester 0.
